tpu_result_drain: RTL and testbench

//  Reader side of the TPU output buffer: drains result rows written by the core datapath.

---
 rtl/tpu_result_drain_pkg.sv | 14 +
 rtl/tpu_result_drain_if.sv | 25 ++
 rtl/drain_row_serializer.sv | 56 +++++
 rtl/tpu_result_drain.sv | 127 ++++++++++++
 tb/tb_tpu_result_drain.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tpu_result_drain_pkg.sv
// Shared types for the TPU result-drain slice: drain FSM state encoding.
package tpu_result_drain_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    SEND,
    DONE
  } drain_state_t;

  localparam int unsigned STALL_CNT_W = 32;

endpackage

// File: rtl/tpu_result_drain_if.sv
// AXI-Stream-style beat channel from the result drain to the system write engine.
interface tpu_result_drain_if #(
  parameter int unsigned TDATA_W = 128
) ();

  logic [TDATA_W-1:0] m_tdata_out;
  logic               m_tvalid_out;
  logic               m_tready_in;
  logic               m_tlast_out;

  modport master (
    output m_tdata_out,
    output m_tvalid_out,
    output m_tlast_out,
    input  m_tready_in
  );

  modport slave (
    input  m_tdata_out,
    input  m_tvalid_out,
    input  m_tlast_out,
    output m_tready_in
  );

endinterface

// File: rtl/drain_row_serializer.sv
// Holds one captured output-buffer row and presents it as BEATS stream beats, lowest lanes first.
module drain_row_serializer #(
  parameter int unsigned SYSTOLIC_ARRAY_WIDTH = 16,
  parameter int unsigned DATA_WIDTH_ACCUM     = 32,
  parameter int unsigned BEAT_LANES           = 4
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             capture_i,
  input  logic                                             last_row_i,
  input  logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH_ACCUM-1:0] row_data_i,
  output logic                                             beat_done_o,
  tpu_result_drain_if.master                               m
);

  localparam int unsigned BEATS  = SYSTOLIC_ARRAY_WIDTH / BEAT_LANES;
  localparam int unsigned BEAT_W = BEAT_LANES * DATA_WIDTH_ACCUM;
  localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH_ACCUM-1:0] row_q;
  logic [CNT_W-1:0]                                 beat_q;
  logic                                             tvalid_q;
  logic                                             handshake;
  logic                                             last_beat;

  assign handshake = tvalid_q & m.m_tready_in;
  assign last_beat = (beat_q == CNT_W'(BEATS - 1));

  // NOTE: all state here is sequential, so every assignment is non-blocking; the
  // row register is deliberately reset so tdata reads zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q    <= '0;
      beat_q   <= '0;
      tvalid_q <= 1'b0;
    end else if (capture_i) begin
      row_q    <= row_data_i;
      beat_q   <= '0;
      tvalid_q <= 1'b1;
    end else if (handshake) begin
      if (last_beat) begin
        beat_q   <= '0;
        tvalid_q <= 1'b0;
      end else begin
        beat_q <= beat_q + CNT_W'(1);
      end
    end
  end

  // tdata/tlast derive only from registers that move on a handshake, so they hold while stalled.
  assign m.m_tdata_out  = row_q[int'(beat_q)*BEAT_W +: BEAT_W];
  assign m.m_tvalid_out = tvalid_q;
  assign m.m_tlast_out  = tvalid_q & last_row_i & last_beat;
  assign beat_done_o    = handshake & last_beat;

endmodule

// File: rtl/tpu_result_drain.sv
// Drains result rows from the TPU output buffer into a beat stream.
// Optional DRAIN_STALL_CNT_EN adds stall_cycles_out (saturating downstream-stall counter).
module tpu_result_drain
  import tpu_result_drain_pkg::*;
#(
  parameter int unsigned SYSTOLIC_ARRAY_WIDTH = 16,
  parameter int unsigned DATA_WIDTH_ACCUM     = 32,
  parameter int unsigned ADDR_WIDTH           = 10,
  parameter int unsigned BEAT_LANES           = 4
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             start_in,
  input  logic [ADDR_WIDTH-1:0]                            base_addr_in,
  input  logic [ADDR_WIDTH:0]                              num_rows_in,
  output logic                                             busy_out,
  output logic                                             done_out,
  output logic [ADDR_WIDTH-1:0]                            ob_rd_addr_out,
  output logic                                             ob_rd_en_out,
  input  logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH_ACCUM-1:0] ob_rd_data_in,
`ifdef DRAIN_STALL_CNT_EN
  output logic [STALL_CNT_W-1:0]                           stall_cycles_out,
`endif
  tpu_result_drain_if.master                               m_axis
);

  drain_state_t          state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   rows_left_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  rd_en_q;
  logic                  last_row;
  logic                  beat_done;

  assign last_row = (rows_left_q == (ADDR_WIDTH+1)'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rows_left_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_in) begin
            addr_q      <= base_addr_in;
            rows_left_q <= num_rows_in;
            busy_q      <= 1'b1;
            if (num_rows_in == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RD;
              rd_en_q <= 1'b1;
            end
          end
        end
        RD: begin
          rd_en_q <= 1'b0;
          state_q <= CAP;
        end
        CAP: state_q <= SEND;
        SEND: begin
          if (beat_done) begin
            // Address wraps modulo 2^ADDR_WIDTH by construction.
            addr_q      <= addr_q + ADDR_WIDTH'(1);
            rows_left_q <= rows_left_q - (ADDR_WIDTH+1)'(1);
            if (last_row) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RD;
              rd_en_q <= 1'b1;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_out       = busy_q;
  assign done_out       = done_q;
  assign ob_rd_en_out   = rd_en_q;
  assign ob_rd_addr_out = addr_q;

  drain_row_serializer #(
    .SYSTOLIC_ARRAY_WIDTH (SYSTOLIC_ARRAY_WIDTH),
    .DATA_WIDTH_ACCUM     (DATA_WIDTH_ACCUM),
    .BEAT_LANES           (BEAT_LANES)
  ) u_serializer (
    .clk         (clk),
    .rst         (rst),
    .capture_i   (state_q == CAP),
    .last_row_i  (last_row),
    .row_data_i  (ob_rd_data_in),
    .beat_done_o (beat_done),
    .m           (m_axis)
  );

`ifdef DRAIN_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (state_q == IDLE && start_in) begin
      stall_q <= '0;
    end else if (state_q == SEND && m_axis.m_tvalid_out && !m_axis.m_tready_in &&
                 stall_q != '1) begin
      stall_q <= stall_q + STALL_CNT_W'(1);
    end
  end

  assign stall_cycles_out = stall_q;
`endif

endmodule

// File: tb/tb_tpu_result_drain.sv
// Directed bench for tpu_result_drain: payload order, addressing, latency, stalls, reset, start-while-busy.
module tb_tpu_result_drain;

  localparam int W     = 16;
  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int BL    = 4;
  localparam int TW    = BL * DW;

  logic            clk = 1'b0;
  logic            rst;
  logic            start_in;
  logic [AW-1:0]   base_addr_in;
  logic [AW:0]     num_rows_in;
  logic            busy_out;
  logic            done_out;
  logic [AW-1:0]   ob_rd_addr_out;
  logic            ob_rd_en_out;
  logic [W*DW-1:0] ob_rd_data_in = '0;
`ifdef DRAIN_STALL_CNT_EN
  logic [31:0]     stall_cycles_out;
`endif

  tpu_result_drain_if #(.TDATA_W(TW)) axis ();

  tpu_result_drain #(
    .SYSTOLIC_ARRAY_WIDTH (W),
    .DATA_WIDTH_ACCUM     (DW),
    .ADDR_WIDTH           (AW),
    .BEAT_LANES           (BL)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start_in         (start_in),
    .base_addr_in     (base_addr_in),
    .num_rows_in      (num_rows_in),
    .busy_out         (busy_out),
    .done_out         (done_out),
    .ob_rd_addr_out   (ob_rd_addr_out),
    .ob_rd_en_out     (ob_rd_en_out),
    .ob_rd_data_in    (ob_rd_data_in),
`ifdef DRAIN_STALL_CNT_EN
    .stall_cycles_out (stall_cycles_out),
`endif
    .m_axis           (axis)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Lane l of row r holds r*256 + l.
  function automatic logic [W*DW-1:0] row_of(input int r);
    logic [W*DW-1:0] v;
    for (int l = 0; l < W; l++) v[l*DW +: DW] = DW'(r * 256 + l);
    return v;
  endfunction

  function automatic logic [TW-1:0] exp_beat(input int r, input int b);
    logic [TW-1:0] v;
    for (int k = 0; k < BL; k++) v[k*DW +: DW] = DW'(r * 256 + b * BL + k);
    return v;
  endfunction

  // Output-buffer model with one cycle read latency.
  always @(posedge clk) if (ob_rd_en_out) ob_rd_data_in <= row_of(int'(ob_rd_addr_out));

  bit ready_alt   = 1'b0;
  bit ready_phase = 1'b0;
  always @(posedge clk) begin
    #1;
    ready_phase = ~ready_phase;
    axis.m_tready_in = ready_alt ? ready_phase : 1'b1;
  end

  logic [TW-1:0] beat_data_q[$];
  bit            beat_last_q[$];
  int            beat_cyc_q[$];
  int            rd_addr_q[$];
  int            rd_cyc_q[$];
  int            done_cyc_q[$];
  int            busy_cyc_q[$];
  int            tvalid_cnt;
  int            stall_cnt;
  bit            prev_stall = 1'b0;
  logic [TW-1:0] prev_data;
  logic          prev_last;

  always @(negedge clk) begin
    if (prev_stall) begin
      tests_run++;
      if (axis.m_tvalid_out !== 1'b1 || axis.m_tdata_out !== prev_data ||
          axis.m_tlast_out !== prev_last) begin
        tests_failed++;
        $display("FAIL axis_hold: got valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                 axis.m_tvalid_out, axis.m_tdata_out, axis.m_tlast_out, prev_data, prev_last);
      end
    end
    if (ob_rd_en_out === 1'b1) begin
      rd_addr_q.push_back(int'(ob_rd_addr_out));
      rd_cyc_q.push_back(cyc);
    end
    if (axis.m_tvalid_out === 1'b1) begin
      tvalid_cnt++;
      if (axis.m_tready_in === 1'b1) begin
        beat_data_q.push_back(axis.m_tdata_out);
        beat_last_q.push_back(axis.m_tlast_out);
        beat_cyc_q.push_back(cyc);
      end else begin
        stall_cnt++;
      end
    end
    if (done_out === 1'b1) done_cyc_q.push_back(cyc);
    if (busy_out === 1'b1) busy_cyc_q.push_back(cyc);
    prev_stall = (axis.m_tvalid_out === 1'b1 && axis.m_tready_in === 1'b0 && rst === 1'b0);
    prev_data  = axis.m_tdata_out;
    prev_last  = axis.m_tlast_out;
  end

  task automatic clear_mon();
    beat_data_q.delete(); beat_last_q.delete(); beat_cyc_q.delete();
    rd_addr_q.delete(); rd_cyc_q.delete(); done_cyc_q.delete(); busy_cyc_q.delete();
    tvalid_cnt = 0;
    stall_cnt  = 0;
  endtask

  // Pulses start and waits for the drain to finish; optionally pulses a second start
  // inject_at cycles later with different parameters.
  task automatic run_drain(input int base, input int rows, input int inject_at,
                           input int base2, input int rows2, output int start_cyc);
    clear_mon();
    @(posedge clk); #1;
    start_in     = 1'b1;
    base_addr_in = AW'(base);
    num_rows_in  = (AW+1)'(rows);
    start_cyc    = cyc;
    @(posedge clk); #1;
    start_in = 1'b0;
    for (int n = 1; n <= 2000; n++) begin
      if (done_cyc_q.size() != 0 && busy_out === 1'b0) break;
      if (n == 2000) begin
        tests_run++;
        tests_failed++;
        $display("FAIL drain_timeout: got busy=%b after 2000 cycles, required done and idle", busy_out);
      end
      if (n == inject_at) begin
        start_in     = 1'b1;
        base_addr_in = AW'(base2);
        num_rows_in  = (AW+1)'(rows2);
      end else begin
        start_in = 1'b0;
      end
      @(posedge clk); #1;
    end
    start_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_in = 1'b0; base_addr_in = '0; num_rows_in = '0;
    axis.m_tready_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({busy_out, done_out, ob_rd_en_out, axis.m_tvalid_out, axis.m_tlast_out} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got busy/done/rd_en/tvalid/tlast=%b, required 00000",
               {busy_out, done_out, ob_rd_en_out, axis.m_tvalid_out, axis.m_tlast_out});
    end
    tests_run++;
    if (ob_rd_addr_out !== '0 || axis.m_tdata_out !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: got rd_addr=%h tdata=%h, required 0 and 0",
               ob_rd_addr_out, axis.m_tdata_out);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single_row();
    int sc;
    run_drain(0, 1, 0, 0, 0, sc);
    tests_run++;
    if (beat_data_q.size() != 4) begin
      tests_failed++;
      $display("FAIL single_beats: got %0d beats, required 4", beat_data_q.size());
    end
    for (int b = 0; b < 4 && b < beat_data_q.size(); b++) begin
      tests_run++;
      if (beat_data_q[b] !== exp_beat(0, b) || beat_last_q[b] !== (b == 3)) begin
        tests_failed++;
        $display("FAIL single_beat%0d: got data=%h last=%b, required data=%h last=%b",
                 b, beat_data_q[b], beat_last_q[b], exp_beat(0, b), (b == 3));
      end
    end
    tests_run++;
    if (rd_cyc_q.size() != 1 || rd_cyc_q[0] - sc != 1 || rd_addr_q[0] != 0) begin
      tests_failed++;
      $display("FAIL single_rd: got %0d reads (first rel cycle %0d), required one read of addr 0 in cycle 1",
               rd_cyc_q.size(), (rd_cyc_q.size() != 0) ? rd_cyc_q[0] - sc : -1);
    end
    tests_run++;
    if (beat_cyc_q.size() == 0 || beat_cyc_q[0] - sc != 3) begin
      tests_failed++;
      $display("FAIL single_first_valid: got rel cycle %0d, required 3",
               (beat_cyc_q.size() != 0) ? beat_cyc_q[0] - sc : -1);
    end
    tests_run++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] - sc != 7) begin
      tests_failed++;
      $display("FAIL single_done: got %0d pulses (first rel cycle %0d), required one in cycle 7",
               done_cyc_q.size(), (done_cyc_q.size() != 0) ? done_cyc_q[0] - sc : -1);
    end
  endtask

  task automatic test_multi_row();
    int sc;
    run_drain(5, 3, 0, 0, 0, sc);
    tests_run++;
    if (rd_addr_q.size() != 3 || rd_addr_q[0] != 5 || rd_addr_q[1] != 6 || rd_addr_q[2] != 7) begin
      tests_failed++;
      $display("FAIL multi_addr: got %0d reads, required addresses 5,6,7", rd_addr_q.size());
    end
    tests_run++;
    if (beat_data_q.size() != 12) begin
      tests_failed++;
      $display("FAIL multi_beats: got %0d beats, required 12", beat_data_q.size());
    end
    for (int i = 0; i < 12 && i < beat_data_q.size(); i++) begin
      tests_run++;
      if (beat_data_q[i] !== exp_beat(5 + i / 4, i % 4) || beat_last_q[i] !== (i == 11)) begin
        tests_failed++;
        $display("FAIL multi_beat%0d: got data=%h last=%b, required data=%h last=%b",
                 i, beat_data_q[i], beat_last_q[i], exp_beat(5 + i / 4, i % 4), (i == 11));
      end
    end
    for (int r = 1; r < rd_cyc_q.size(); r++) begin
      tests_run++;
      if (rd_cyc_q[r] - rd_cyc_q[r-1] < 6) begin
        tests_failed++;
        $display("FAIL multi_row_gap: got %0d cycles between reads, required at least 6",
                 rd_cyc_q[r] - rd_cyc_q[r-1]);
      end
    end
  endtask

  task automatic test_backpressure();
    int sc;
    ready_alt = 1'b1;
    run_drain(10, 2, 0, 0, 0, sc);
    ready_alt = 1'b0;
    tests_run++;
    if (beat_data_q.size() != 8) begin
      tests_failed++;
      $display("FAIL bp_beats: got %0d beats, required 8", beat_data_q.size());
    end
    for (int i = 0; i < 8 && i < beat_data_q.size(); i++) begin
      tests_run++;
      if (beat_data_q[i] !== exp_beat(10 + i / 4, i % 4) || beat_last_q[i] !== (i == 7)) begin
        tests_failed++;
        $display("FAIL bp_beat%0d: got data=%h last=%b, required data=%h last=%b",
                 i, beat_data_q[i], beat_last_q[i], exp_beat(10 + i / 4, i % 4), (i == 7));
      end
    end
    tests_run++;
    if (stall_cnt == 0) begin
      tests_failed++;
      $display("FAIL bp_stalls_seen: got 0 stalled cycles, required at least 1");
    end
`ifdef DRAIN_STALL_CNT_EN
    tests_run++;
    if (stall_cycles_out !== 32'(stall_cnt)) begin
      tests_failed++;
      $display("FAIL bp_stall_counter: got %0d, required %0d", stall_cycles_out, stall_cnt);
    end
`endif
  endtask

  task automatic test_addr_wrap();
    int sc;
    run_drain(1022, 3, 0, 0, 0, sc);
    tests_run++;
    if (rd_addr_q.size() != 3 || rd_addr_q[0] != 1022 || rd_addr_q[1] != 1023 || rd_addr_q[2] != 0) begin
      tests_failed++;
      $display("FAIL wrap_addr: got %0d reads, required addresses 1022,1023,0", rd_addr_q.size());
    end
    tests_run++;
    if (beat_data_q.size() != 12) begin
      tests_failed++;
      $display("FAIL wrap_beats: got %0d beats, required 12", beat_data_q.size());
    end
    for (int i = 0; i < 12 && i < beat_data_q.size(); i++) begin
      tests_run++;
      if (beat_data_q[i] !== exp_beat((1022 + i / 4) % 1024, i % 4)) begin
        tests_failed++;
        $display("FAIL wrap_beat%0d: got %h, required %h",
                 i, beat_data_q[i], exp_beat((1022 + i / 4) % 1024, i % 4));
      end
    end
  endtask

  task automatic test_zero_rows();
    int sc;
    run_drain(3, 0, 0, 0, 0, sc);
    tests_run++;
    if (rd_addr_q.size() != 0 || tvalid_cnt != 0) begin
      tests_failed++;
      $display("FAIL zero_activity: got %0d reads and %0d tvalid cycles, required 0 and 0",
               rd_addr_q.size(), tvalid_cnt);
    end
    tests_run++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] - sc != 1) begin
      tests_failed++;
      $display("FAIL zero_done: got %0d pulses (first rel cycle %0d), required one in cycle 1",
               done_cyc_q.size(), (done_cyc_q.size() != 0) ? done_cyc_q[0] - sc : -1);
    end
    tests_run++;
    if (busy_cyc_q.size() != 1 || busy_cyc_q[0] - sc != 1) begin
      tests_failed++;
      $display("FAIL zero_busy: got %0d busy cycles (first rel cycle %0d), required only cycle 1",
               busy_cyc_q.size(), (busy_cyc_q.size() != 0) ? busy_cyc_q[0] - sc : -1);
    end
  endtask

  task automatic test_reset_mid_send();
    int sc;
    bit reached = 1'b0;
    clear_mon();
    @(posedge clk); #1;
    start_in = 1'b1; base_addr_in = '0; num_rows_in = (AW+1)'(1);
    @(posedge clk); #1;
    start_in = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk); #1;
      if (beat_data_q.size() == 3) begin
        reached = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!reached) begin
      tests_failed++;
      $display("FAIL rst_reach_beat2: got %0d beats, required beat 2 to be presented", beat_data_q.size());
    end
    rst = 1'b1;
    done_cyc_q.delete();
    @(negedge clk);
    tests_run++;
    if (axis.m_tvalid_out !== 1'b0 || busy_out !== 1'b0 || done_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_send: got tvalid=%b busy=%b done=%b, required 0 0 0",
               axis.m_tvalid_out, busy_out, done_out);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    tests_run++;
    if (done_cyc_q.size() != 0) begin
      tests_failed++;
      $display("FAIL rst_no_done: got %0d done pulses, required 0", done_cyc_q.size());
    end
    run_drain(0, 1, 0, 0, 0, sc);
    tests_run++;
    if (beat_data_q.size() != 4) begin
      tests_failed++;
      $display("FAIL rst_redrain_beats: got %0d beats, required 4", beat_data_q.size());
    end
    for (int b = 0; b < 4 && b < beat_data_q.size(); b++) begin
      tests_run++;
      if (beat_data_q[b] !== exp_beat(0, b) || beat_last_q[b] !== (b == 3)) begin
        tests_failed++;
        $display("FAIL rst_redrain_beat%0d: got data=%h last=%b, required data=%h last=%b",
                 b, beat_data_q[b], beat_last_q[b], exp_beat(0, b), (b == 3));
      end
    end
  endtask

  task automatic test_start_while_busy();
    int sc;
    run_drain(20, 2, 4, 100, 5, sc);
    tests_run++;
    if (rd_addr_q.size() != 2 || rd_addr_q[0] != 20 || rd_addr_q[1] != 21) begin
      tests_failed++;
      $display("FAIL busy_start_addr: got %0d reads, required addresses 20,21", rd_addr_q.size());
    end
    tests_run++;
    if (beat_data_q.size() != 8 || done_cyc_q.size() != 1) begin
      tests_failed++;
      $display("FAIL busy_start_beats: got %0d beats and %0d done pulses, required 8 and 1",
               beat_data_q.size(), done_cyc_q.size());
    end
    for (int i = 0; i < 8 && i < beat_data_q.size(); i++) begin
      tests_run++;
      if (beat_data_q[i] !== exp_beat(20 + i / 4, i % 4) || beat_last_q[i] !== (i == 7)) begin
        tests_failed++;
        $display("FAIL busy_start_beat%0d: got data=%h last=%b, required data=%h last=%b",
                 i, beat_data_q[i], beat_last_q[i], exp_beat(20 + i / 4, i % 4), (i == 7));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_multi_row();
    test_backpressure();
    test_addr_wrap();
    test_zero_rows();
    test_reset_mid_send();
    test_start_while_busy();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
